// File: rtl/useq_pkg.sv
// Shared mode and select encodings for the microsequencer next-address unit.
package useq_pkg;

  localparam logic [3:0] MODE_ENC         = 4'b0000;
  localparam logic [3:0] MODE_FETCH       = 4'b0001;
  localparam logic [3:0] MODE_CR          = 4'b0010;
  localparam logic [3:0] MODE_INC         = 4'b0011;
  localparam logic [3:0] MODE_C_CR_ENC    = 4'b0100;
  localparam logic [3:0] MODE_C_CR_INC    = 4'b0101;
  localparam logic [3:0] MODE_C_ENC_INC   = 4'b0110;
  localparam logic [3:0] MODE_C_CR_FETCH  = 4'b0111;
  localparam logic [3:0] MODE_CALL        = 4'b1000;
  localparam logic [3:0] MODE_RET         = 4'b1001;
  localparam logic [3:0] MODE_CCALL       = 4'b1010;

  localparam logic [1:0] SEL_ENC   = 2'b00;
  localparam logic [1:0] SEL_FETCH = 2'b01;
  localparam logic [1:0] SEL_CR    = 2'b10;
  localparam logic [1:0] SEL_INC   = 2'b11;

endpackage

// File: rtl/useq_ret_stack.sv
// Microsubroutine return-address LIFO. Push on full and pop on empty are ignored;
// the caller flags those as errors.
module useq_ret_stack #(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [ADDR_W-1:0] i_data,
  output logic [ADDR_W-1:0] o_top,
  output logic              o_full,
  output logic              o_empty
);

  localparam int PTR_W = $clog2(STACK_DEPTH);

  logic [PTR_W:0]      r_cnt;
  logic [ADDR_W-1:0]   r_mem [STACK_DEPTH];
  logic [PTR_W-1:0]    w_top_idx;

  assign o_full    = (r_cnt == (PTR_W+1)'(STACK_DEPTH));
  assign o_empty   = (r_cnt == '0);
  assign w_top_idx = r_cnt[PTR_W-1:0] - PTR_W'(1);
  assign o_top     = r_mem[w_top_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_push && !o_full) begin
      r_cnt <= r_cnt + 1'b1;
    end else if (i_pop && !o_empty) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Storage carries no reset; only the occupancy count is control state.
  always_ff @(posedge clk) begin
    if (i_push && !o_full) begin
      r_mem[r_cnt[PTR_W-1:0]] <= i_data;
    end
  end

endmodule

// File: rtl/microseq_next_addr.sv
// Microsequencer next-address decode and state_addr register.
// Define USEQ_STACK_EN to build the CALL/RET/CCALL return stack.
module microseq_next_addr
  import useq_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int FETCH_ADDR  = 1,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        mode,
  input  logic              cond_S,
  input  logic              hold,
  input  logic [ADDR_W-1:0] enc_addr,
  input  logic [ADDR_W-1:0] cr_addr,
  output logic [1:0]        sel,
  output logic [ADDR_W-1:0] state_addr,
  output logic              stk_err
);

  logic [ADDR_W-1:0] r_state_addr;
  logic [ADDR_W-1:0] w_inc;
  logic [ADDR_W-1:0] w_fetch;
  logic [ADDR_W-1:0] w_target;
  logic [1:0]        w_sel_dec;
  logic              w_push;
  logic              w_pop;
  logic              w_stk_empty;
  logic              w_stk_full;
  logic [ADDR_W-1:0] w_stk_top;

  assign w_inc   = r_state_addr + ADDR_W'(1);
  assign w_fetch = ADDR_W'(FETCH_ADDR);

  always_comb begin
    w_target  = w_inc;
    w_sel_dec = SEL_INC;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    case (mode)
      MODE_ENC:        begin w_target = enc_addr; w_sel_dec = SEL_ENC;   end
      MODE_FETCH:      begin w_target = w_fetch;  w_sel_dec = SEL_FETCH; end
      MODE_CR:         begin w_target = cr_addr;  w_sel_dec = SEL_CR;    end
      MODE_C_CR_ENC:   begin
        w_target  = cond_S ? cr_addr : enc_addr;
        w_sel_dec = cond_S ? SEL_CR : SEL_ENC;
      end
      MODE_C_CR_INC:   if (cond_S) begin w_target = cr_addr;  w_sel_dec = SEL_CR;  end
      MODE_C_ENC_INC:  if (cond_S) begin w_target = enc_addr; w_sel_dec = SEL_ENC; end
      MODE_C_CR_FETCH: begin
        w_target  = cond_S ? cr_addr : w_fetch;
        w_sel_dec = cond_S ? SEL_CR : SEL_FETCH;
      end
`ifdef USEQ_STACK_EN
      MODE_CALL:       begin w_push = 1'b1; w_target = cr_addr; w_sel_dec = SEL_CR; end
      MODE_RET:        begin
        w_pop    = 1'b1;
        w_target = w_stk_empty ? w_fetch : w_stk_top;
      end
      MODE_CCALL:      if (cond_S) begin w_push = 1'b1; w_target = cr_addr; w_sel_dec = SEL_CR; end
`endif
      default: ;
    endcase
  end

  assign sel        = reset ? SEL_FETCH : w_sel_dec;
  assign state_addr = r_state_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state_addr <= w_fetch;
    end else if (!hold) begin
      r_state_addr <= w_target;
    end
  end

`ifdef USEQ_STACK_EN
  logic w_push_en;
  logic w_pop_en;
  logic r_stk_err;

  assign w_push_en = w_push & ~hold & ~reset;
  assign w_pop_en  = w_pop  & ~hold & ~reset;

  useq_ret_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push_en),
    .i_pop   (w_pop_en),
    .i_data  (w_inc),
    .o_top   (w_stk_top),
    .o_full  (w_stk_full),
    .o_empty (w_stk_empty)
  );

  // Sticky until reset: overflowed push or underflowed pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stk_err <= 1'b0;
    end else if ((w_push_en && w_stk_full) || (w_pop_en && w_stk_empty)) begin
      r_stk_err <= 1'b1;
    end
  end

  assign stk_err = r_stk_err;
`else
  logic w_unused;

  assign w_stk_empty = 1'b1;
  assign w_stk_full  = 1'b0;
  assign w_stk_top   = '0;
  assign stk_err     = 1'b0;
  assign w_unused    = ^{w_push, w_pop, w_stk_empty, w_stk_full, w_stk_top, STACK_DEPTH};
`endif

endmodule

// File: tb/tb_microseq_next_addr.sv
// Self-checking bench for microseq_next_addr: per-cycle reference model plus
// directed literal checks. Stack scenarios run when USEQ_STACK_EN is defined.
module tb_microseq_next_addr;

  localparam int ADDR_W     = 8;
  localparam int FETCH_ADDR = 1;
  localparam int DEPTH      = 4;
`ifdef USEQ_STACK_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic [3:0]        mode;
  logic              cond_S;
  logic              hold;
  logic [ADDR_W-1:0] enc_addr;
  logic [ADDR_W-1:0] cr_addr;
  logic [1:0]        sel;
  logic [ADDR_W-1:0] state_addr;
  logic              stk_err;

  int checks   = 0;
  int failures = 0;

  microseq_next_addr #(
    .ADDR_W      (ADDR_W),
    .FETCH_ADDR  (FETCH_ADDR),
    .STACK_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mode       (mode),
    .cond_S     (cond_S),
    .hold       (hold),
    .enc_addr   (enc_addr),
    .cr_addr    (cr_addr),
    .sel        (sel),
    .state_addr (state_addr),
    .stk_err    (stk_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: source kinds 0 ENC, 1 FETCH, 2 CR, 3 INC, 4 CALL, 5 RET
  int unsigned  m_addr;
  bit           m_err;
  bit           m_valid = 1'b0;
  int unsigned  m_stk[$];

  function automatic int src_of(input logic [3:0] md, input logic c);
    case (md)
      4'd0: return 0;
      4'd1: return 1;
      4'd2: return 2;
      4'd4: return c ? 2 : 0;
      4'd5: return c ? 2 : 3;
      4'd6: return c ? 0 : 3;
      4'd7: return c ? 2 : 1;
      4'd8: return STK ? 4 : 3;
      4'd9: return STK ? 5 : 3;
      4'd10: return (STK && c) ? 4 : 3;
      default: return 3;
    endcase
  endfunction

  function automatic int exp_sel(input logic rst, input logic [3:0] md, input logic c);
    int s;
    if (rst) return 1;
    s = src_of(md, c);
    if (s == 4) return 2;
    if (s == 5) return 3;
    return s;
  endfunction

  always @(posedge clk) begin
    int s;
    int unsigned inc;
    if (reset) begin
      m_addr  = FETCH_ADDR;
      m_err   = 1'b0;
      m_stk.delete();
      m_valid = 1'b1;
    end else if (m_valid && !hold) begin
      s   = src_of(mode, cond_S);
      inc = (m_addr + 1) % 256;
      case (s)
        0: m_addr = enc_addr;
        1: m_addr = FETCH_ADDR;
        2: m_addr = cr_addr;
        4: begin
          if (m_stk.size() < DEPTH) m_stk.push_back(inc);
          else m_err = 1'b1;
          m_addr = cr_addr;
        end
        5: begin
          if (m_stk.size() == 0) begin
            m_err  = 1'b1;
            m_addr = FETCH_ADDR;
          end else begin
            m_addr = m_stk.pop_back();
          end
        end
        default: m_addr = inc;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_sel", {30'd0, sel}, exp_sel(reset, mode, cond_S));
      chk("model_addr", {24'd0, state_addr}, m_addr);
      chk("model_err", {31'd0, stk_err}, {31'd0, m_err});
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1; mode = 4'd3; cond_S = 1'b0; hold = 1'b0;
    enc_addr = 8'h33; cr_addr = 8'h00;
    tick(); tick();
    chk("rst_addr", state_addr, 1);
    chk("rst_sel", sel, 1);
    chk("rst_err", stk_err, 0);

    reset = 1'b0; #1;
    chk("inc_sel", sel, 3);
    tick(); chk("inc1", state_addr, 8'h02);
    tick(); chk("inc2", state_addr, 8'h03);
    tick(); chk("inc3", state_addr, 8'h04);

    mode = 4'd2; cr_addr = 8'hFF; tick(); chk("cr_ff", state_addr, 8'hFF);
    mode = 4'd3; tick(); chk("wrap", state_addr, 8'h00);

    mode = 4'd5; cr_addr = 8'h40; cond_S = 1'b1; #1;
    chk("c5_t_sel", sel, 2);
    tick(); chk("c5_t", state_addr, 8'h40);
    cond_S = 1'b0; #1;
    chk("c5_f_sel", sel, 3);
    tick(); chk("c5_f", state_addr, 8'h41);

    mode = 4'd4; #1; chk("c4_f_sel", sel, 0);
    tick(); chk("c4_f", state_addr, 8'h33);
    mode = 4'd7; #1; chk("c7_f_sel", sel, 1);
    tick(); chk("c7_f", state_addr, 8'h01);
    cond_S = 1'b1; tick(); chk("c7_t", state_addr, 8'h40);
    mode = 4'd6; tick(); chk("c6_t", state_addr, 8'h33);
    cond_S = 1'b0; tick(); chk("c6_f", state_addr, 8'h34);

    mode = 4'd2; cr_addr = 8'h5A; hold = 1'b1; #1;
    chk("hold_sel", sel, 2);
    repeat (4) tick();
    chk("hold_frozen", state_addr, 8'h34);
    hold = 1'b0; tick(); chk("hold_release", state_addr, 8'h5A);
    mode = 4'd12; tick(); chk("m12_inc", state_addr, 8'h5B);
    mode = 4'd15; tick(); chk("m15_inc", state_addr, 8'h5C);

`ifndef USEQ_STACK_EN
    mode = 4'd8; cr_addr = 8'h80; #1; chk("nostk_call_sel", sel, 3);
    tick(); chk("nostk_call", state_addr, 8'h5D);
    mode = 4'd9; tick(); chk("nostk_ret", state_addr, 8'h5E);
    mode = 4'd10; cond_S = 1'b1; tick(); chk("nostk_ccall", state_addr, 8'h5F);
    chk("nostk_err", stk_err, 0);
`else
    mode = 4'd2; cr_addr = 8'h10; tick();
    mode = 4'd8; cr_addr = 8'h80; #1; chk("call_sel", sel, 2);
    tick(); chk("call", state_addr, 8'h80);
    mode = 4'd9; #1; chk("ret_sel", sel, 3);
    tick(); chk("ret", state_addr, 8'h11);
    chk("ret_err", stk_err, 0);
    tick(); chk("ret_empty", state_addr, 8'h01);
    chk("ret_empty_err", stk_err, 1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rst_clr_err", stk_err, 0);

    mode = 4'd8; cr_addr = 8'h20;
    repeat (4) tick();
    chk("call4_err", stk_err, 0);
    tick();
    chk("call5_err", stk_err, 1);
    chk("call5_addr", state_addr, 8'h20);
    mode = 4'd9; tick(); chk("ovf_ret", state_addr, 8'h21);

    reset = 1'b1; tick(); reset = 1'b0;
    mode = 4'd8; cr_addr = 8'h30; tick(); chk("mid_call", state_addr, 8'h30);
    hold = 1'b1; tick(); chk("hold_call", state_addr, 8'h30);
    reset = 1'b1; tick();
    chk("mid_rst_addr", state_addr, 8'h01);
    chk("mid_rst_err", stk_err, 0);
    reset = 1'b0; hold = 1'b0; mode = 4'd9; tick();
    chk("mid_rst_empty", state_addr, 8'h01);
    chk("mid_rst_empty_err", stk_err, 1);

    reset = 1'b1; tick(); reset = 1'b0;
    mode = 4'd10; cond_S = 1'b0; #1; chk("ccall_f_sel", sel, 3);
    tick(); chk("ccall_f", state_addr, 8'h02);
    cond_S = 1'b1; cr_addr = 8'h44; tick(); chk("ccall_t", state_addr, 8'h44);
    mode = 4'd9; tick(); chk("ccall_ret", state_addr, 8'h03);
    chk("ccall_err", stk_err, 0);
`endif

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
